regfile_write_arbiter: RTL



---
 rtl/regfile_write_arbiter_pkg.sv | 17 +
 rtl/regfile_write_arbiter_wb_fifo.sv | 64 ++++++
 rtl/regfile_write_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its long-result FIFO.
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] regIdx_t;

  localparam regIdx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small in-order FIFO for long-latency write-back results; exposes per-slot
// contents so the owner can decode which destinations are still buffered.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           pushData,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           slotValid,
  output logic [DEPTH*WIDTH-1:0]     slotData
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  assign head  = mem[rdPtr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      slotValid <= '0;
    end else begin
      // Caller guarantees push only when not full and pop only when not empty,
      // so the two slot updates never target the same index.
      if (pop) begin
        rdPtr            <= rdPtr + PTR_W'(1);
        slotValid[rdPtr] <= 1'b0;
      end
      if (push) begin
        wrPtr            <= wrPtr + PTR_W'(1);
        slotValid[wrPtr] <= 1'b1;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_comb begin
    slotData = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slotData[i*WIDTH +: WIDTH] = mem[i];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// write-back stage and buffered multi-cycle results, with starvation relief.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      pipeValid,
  input  logic [ADDR_W-1:0]         pipeRd,
  input  logic [DATA_W-1:0]         pipeData,
  output logic                      pipeStall,
  input  logic                      longValid,
  input  logic [ADDR_W-1:0]         longRd,
  input  logic [DATA_W-1:0]         longData,
  output logic                      longReady,
  output logic                      rfWriteEn,
  output logic [ADDR_W-1:0]         rfRd,
  output logic [DATA_W-1:0]         rfWriteData,
  output logic [(1<<ADDR_W)-1:0]    pendingMask
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic                          fifoPush;
  logic                          fifoPop;
  logic                          fifoFull;
  logic                          fifoEmpty;
  logic [CNT_W-1:0]              fifoCount;
  logic [ENTRY_W-1:0]            fifoHead;
  logic [FIFO_DEPTH-1:0]         slotValid;
  logic [FIFO_DEPTH*ENTRY_W-1:0] slotData;

  logic [SC_W-1:0] starveCnt;
  logic            forced;
  logic            pipeReq;
  grant_e          grant;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) uFifo (
    .clock     (clock),
    .resetN    (resetN),
    .push      (fifoPush),
    .pop       (fifoPop),
    .pushData  ({longRd, longData}),
    .head      (fifoHead),
    .count     (fifoCount),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .slotValid (slotValid),
    .slotData  (slotData)
  );

  // Stall derives only from registered state so the pipeline can use it early.
  assign forced    = (starveCnt == SC_W'(STARVE_LIMIT)) && (fifoCount != '0);
  assign pipeStall = forced;
  assign longReady = !fifoFull;
  assign pipeReq   = pipeValid && (pipeRd != ADDR_W'(REG_ZERO));
  assign fifoPush  = longValid && !fifoFull && (longRd != ADDR_W'(REG_ZERO));
  assign fifoPop   = (grant == GRANT_FIFO);

  always_comb begin
    grant = GRANT_NONE;
    if (forced)          grant = GRANT_FIFO;
    else if (pipeReq)    grant = GRANT_PIPE;
    else if (!fifoEmpty) grant = GRANT_FIFO;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      starveCnt <= '0;
    end else if (fifoEmpty || grant == GRANT_FIFO) begin
      starveCnt <= '0;
    end else if (starveCnt != SC_W'(STARVE_LIMIT)) begin
      starveCnt <= starveCnt + SC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rfWriteEn   <= 1'b0;
      rfRd        <= '0;
      rfWriteData <= '0;
    end else begin
      rfWriteEn <= (grant != GRANT_NONE);
      if (grant == GRANT_PIPE) begin
        rfRd        <= pipeRd;
        rfWriteData <= pipeData;
      end else if (grant == GRANT_FIFO) begin
        rfRd        <= fifoHead[DATA_W +: ADDR_W];
        rfWriteData <= fifoHead[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (slotValid[i]) pendingMask[slotData[i*ENTRY_W + DATA_W +: ADDR_W]] = 1'b1;
    end
    if (rfWriteEn) pendingMask[rfRd] = 1'b1;
  end

endmodule
